// File: rtl/cnn_pkg.sv
// Shared CNN package: default geometry constants and the weight loader FSM state type.
// Used by the CNN top, feature_mem and weight_loader.
package cnn_pkg;

  localparam int unsigned DefaultKernelSize  = 3;
  localparam int unsigned DefaultNumFeatures = 10;

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StWrite,
    StDone
  } loader_state_e;

endpackage

// File: rtl/weight_loader.sv
// weight_loader: deserialises a 1-bit weight stream into one KK-bit word per feature and
// writes NUM_FEATURES words to the feature memory at consecutive addresses.
//
// Ports:
//   clk             - clock, all state changes on the rising edge
//   rst             - asynchronous active-high reset
//   start           - single-cycle load request, honoured only when idle
//   w_valid/w_data  - serial weight stream (valid / bit)
//   w_ready         - loader accepts w_data this cycle
//   address_w       - feature-memory write address
//   feature_weights - packed weights; bit k is the k-th received bit of the feature
//   feature_WrEn    - feature-memory write strobe
//   busy            - load sequence in progress
//   done            - one-cycle pulse after the final feature write
module weight_loader
  import cnn_pkg::*;
#(
  parameter int unsigned KERNEL_SIZE  = DefaultKernelSize,
  parameter int unsigned NUM_FEATURES = DefaultNumFeatures
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic                                 w_valid,
  input  logic                                 w_data,
  output logic                                 w_ready,
  output logic [$clog2(NUM_FEATURES):0]        address_w,
  output logic [KERNEL_SIZE*KERNEL_SIZE-1:0]   feature_weights,
  output logic                                 feature_WrEn,
  output logic                                 busy,
  output logic                                 done
);

  localparam int unsigned KK    = KERNEL_SIZE * KERNEL_SIZE;
  localparam int unsigned CntW  = $clog2(KK) + 1;
  localparam int unsigned AddrW = $clog2(NUM_FEATURES) + 1;

  localparam logic [CntW-1:0]  LastCnt  = CntW'(KK - 1);
  localparam logic [AddrW-1:0] LastAddr = AddrW'(NUM_FEATURES - 1);

  loader_state_e   state;
  logic [CntW-1:0] elem_cnt;

  // Outputs are registered alongside the state so they change only on the clock edge
  // (or immediately on reset).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= StIdle;
      elem_cnt        <= '0;
      address_w       <= '0;
      feature_weights <= '0;
      w_ready         <= 1'b0;
      feature_WrEn    <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          done <= 1'b0;
          if (start) begin
            state     <= StCollect;
            elem_cnt  <= '0;
            address_w <= '0;
            w_ready   <= 1'b1;
            busy      <= 1'b1;
          end
        end

        StCollect: begin
          if (w_valid && w_ready) begin
            // Decoded write keeps the select index the same width as the word.
            for (int unsigned i = 0; i < KK; i++) begin
              if (elem_cnt == CntW'(i)) feature_weights[i] <= w_data;
            end
            if (elem_cnt == LastCnt) begin
              state        <= StWrite;
              w_ready      <= 1'b0;
              feature_WrEn <= 1'b1;
            end else begin
              elem_cnt <= elem_cnt + 1'b1;
            end
          end
        end

        StWrite: begin
          feature_WrEn <= 1'b0;
          if (address_w == LastAddr) begin
            // Address parks at the last feature; no wrap-around write.
            state <= StDone;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state     <= StCollect;
            address_w <= address_w + 1'b1;
            elem_cnt  <= '0;
            w_ready   <= 1'b1;
          end
        end

        StDone: begin
          done  <= 1'b0;
          state <= StIdle;
        end

        default: begin
          state        <= StIdle;
          w_ready      <= 1'b0;
          feature_WrEn <= 1'b0;
          busy         <= 1'b0;
          done         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/weight_loader.md
WEIGHT_LOADER -- requirements
Module: weight_loader

Interface
REQ-001 Parameter: KERNEL_SIZE, default 3, kernel edge length; one feature holds KERNEL_SIZE*KERNEL_SIZE (KK) weights.
REQ-002 Parameter: NUM_FEATURES, default 10, number of features loaded per load sequence.
REQ-003 Port: clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: start  input  1  single-cycle request to begin a load sequence.
REQ-006 Port: w_valid  input  1  serial weight stream valid.
REQ-007 Port: w_data  input  1  serial weight bit (binary weight).
REQ-008 Port: w_ready  output  1  loader accepts w_data this cycle.
REQ-009 Port: address_w  output  $clog2(NUM_FEATURES)+1  feature-memory write address.
REQ-010 Port: feature_weights  output  KK  packed weight word for one feature; bit i = kernel element i.
REQ-011 Port: feature_WrEn  output  1  feature-memory write strobe.
REQ-012 Port: busy  output  1  high from the cycle after start is accepted until done.
REQ-013 Port: done  output  1  one-cycle pulse when the final feature write completes.

Function
REQ-014 FSM states SHALL be IDLE, COLLECT, WRITE, DONE.
REQ-015 IDLE: start=1 -> COLLECT; element counter and address_w cleared to 0; start ignored in every other state.
REQ-016 COLLECT: w_ready SHALL be 1; a transfer occurs only when w_valid and w_ready are both 1 on a rising edge.
REQ-017 The k-th accepted bit of a feature (k = 0..KK-1) SHALL be stored at feature_weights bit k; first received bit -> bit 0.
REQ-018 On the KK-th accepted bit the FSM SHALL move to WRITE on the next edge; w_valid=0 cycles stall without losing count.
REQ-019 WRITE: feature_WrEn=1 for exactly one cycle, with address_w and feature_weights stable and valid in that cycle; w_ready=0.
REQ-020 WRITE exit: if address_w == NUM_FEATURES-1 -> DONE; else address_w increments by 1, element counter clears, -> COLLECT.
REQ-021 DONE: done=1 for one cycle, busy=0, then -> IDLE; address_w holds NUM_FEATURES-1 until the next start.
REQ-022 feature_WrEn SHALL be 0 in every state except WRITE; w_ready SHALL be 0 in every state except COLLECT.
REQ-023 address_w SHALL never exceed NUM_FEATURES-1 (no wrap-around write).
REQ-024 Minimum sequence latency with w_valid held high: NUM_FEATURES*(KK+1) cycles from COLLECT entry to the DONE cycle, inclusive of WRITE cycles.
REQ-025 start asserted in the DONE cycle SHALL be ignored; a new sequence requires start while in IDLE.

Reset
REQ-026 rst=1 SHALL immediately force IDLE, w_ready=0, feature_WrEn=0, busy=0, done=0, address_w=0, feature_weights=0, element counter=0.
REQ-027 rst asserted mid-sequence SHALL abort the sequence; no further feature_WrEn until a new start after rst deasserts.

Structure
REQ-028 FSM state enum and default KERNEL_SIZE/NUM_FEATURES constants SHALL live in the shared cnn package used by the CNN top and feature_mem.
REQ-029 Single module, no sub-modules; element counter width $clog2(KK)+1.

Verification
REQ-030 Defaults, start, 90 bits with w_valid=1 (feature f bits = f[0] repeated) -> 10 feature_WrEn pulses, addresses 0..9, done 1 cycle after last write, 100 cycles COLLECT-to-DONE.
REQ-031 Bit order: feature 0 stream 1,0,0,0,0,0,0,0,1 -> feature_weights = 9'b100000001 at address 0 write.
REQ-032 Stalls: w_valid toggled 1/0 every cycle -> identical write data/addresses as REQ-030; w_ready never 1 in WRITE.
REQ-033 Reset mid-load: rst pulse after 4th feature write -> outputs zero immediately, no feature_WrEn afterward; next start restarts at address 0.
REQ-034 start pulsed while busy and in DONE -> ignored; exactly 10 writes, one done pulse.
REQ-035 NUM_FEATURES=1, KERNEL_SIZE=2: 4 bits -> single write at address 0, done on following cycle.
